// File: rtl/reaction_pkg.sv
// Shared types and constants for the multi-player reaction timer.
package reaction_pkg;

  localparam int BCD_W = 4;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WAIT = 3'd1,
    S_GO   = 3'd2,
    S_DONE = 3'd3,
    S_FOUL = 3'd4
  } state_t;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {v[14:0], ^(v & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/bcd_counter.sv
// Multi-digit decimal up-counter with synchronous clear; saturates at all 9s.
module bcd_counter
  import reaction_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clr,
  input  logic                      inc,
  output logic [BCD_W*DIGITS-1:0]   count,
  output logic                      sat
);

  localparam logic [BCD_W*DIGITS-1:0] ALL_NINES = {DIGITS{4'h9}};

  logic [BCD_W*DIGITS-1:0] count_nxt;
  logic                    carry;

  // Ripple a decimal carry from the least significant digit upward
  always_comb begin
    count_nxt = count;
    carry     = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (count[i*BCD_W +: BCD_W] == 4'd9) begin
          count_nxt[i*BCD_W +: BCD_W] = 4'd0;
        end else begin
          count_nxt[i*BCD_W +: BCD_W] = count[i*BCD_W +: BCD_W] + 4'd1;
          carry = 1'b0;
        end
      end
    end
  end

  assign sat = (count == ALL_NINES);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && !sat) begin
      count <= count_nxt;
    end
  end

endmodule

// File: rtl/reaction_timer_mc.sv
// Multi-player reaction timer: random hold-off, GO lamp, first-press capture in BCD ticks.
// Optional best-time register enabled by defining REACTION_BEST_TIME_EN.
module reaction_timer_mc
  import reaction_pkg::*;
#(
  parameter int N_PLAYERS  = 2,
  parameter int TICK_DIV   = 5000,
  parameter int DIGITS     = 4,
  parameter int DELAY_BASE = 10000,
  localparam int WIN_W     = (N_PLAYERS > 1) ? $clog2(N_PLAYERS) : 1
) (
  input  logic                     sysclk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     clr,
  input  logic [N_PLAYERS-1:0]     btn,
  output logic [2:0]               state,
  output logic                     go_led,
  output logic [BCD_W*DIGITS-1:0]  time_bcd,
  output logic                     done,
  output logic                     timeout,
  output logic [N_PLAYERS-1:0]     foul,
  output logic [WIN_W-1:0]         winner
`ifdef REACTION_BEST_TIME_EN
  ,
  output logic [BCD_W*DIGITS-1:0]  best_bcd
`endif
);

  localparam int NS    = N_PLAYERS + 2;
  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DLY_W = $clog2(DELAY_BASE + 4096) + 1;

  state_t cur, nxt;

  logic [NS-1:0]        raw, sync1, sync2, sync3, pulse;
  logic                 start_p, clr_p, any_btn;
  logic [N_PLAYERS-1:0] btn_p;
  logic [15:0]          lfsr;
  logic [PRE_W-1:0]     presc;
  logic                 tick;
  logic [DLY_W-1:0]     dly_cnt;
  logic                 delay_done;
  logic                 enter_wait, enter_go, to_done, to_foul;
  logic [WIN_W-1:0]     first_idx;
  logic                 cnt_clr, cnt_inc, sat;

  // Two-flop synchronizer plus edge detector on every raw button
  assign raw = {btn, clr, start};

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      sync3 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  assign pulse   = sync2 & ~sync3;
  assign start_p = pulse[0];
  assign clr_p   = pulse[1];
  assign btn_p   = pulse[NS-1:2];
  assign any_btn = |btn_p;

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) lfsr <= LFSR_SEED;
    else        lfsr <= lfsr_step(lfsr);
  end

  // Lowest-index pulsing player wins simultaneous presses
  always_comb begin
    first_idx = '0;
    for (int i = N_PLAYERS - 1; i >= 0; i--) begin
      if (btn_p[i]) first_idx = WIN_W'(i);
    end
  end

  assign tick       = (presc == PRE_W'(TICK_DIV - 1));
  assign delay_done = (dly_cnt == '0) || (tick && (dly_cnt == DLY_W'(1)));

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) cur <= S_IDLE;
    else        cur <= nxt;
  end

  // A foul press beats the final delay tick; reaching all 9s beats a press
  always_comb begin
    nxt = cur;
    if (clr_p) begin
      nxt = S_IDLE;
    end else begin
      case (cur)
        S_IDLE:         if (start_p) nxt = S_WAIT;
        S_WAIT: begin
          if (any_btn)         nxt = S_FOUL;
          else if (delay_done) nxt = S_GO;
        end
        S_GO:           if (sat || any_btn) nxt = S_DONE;
        S_DONE, S_FOUL: if (start_p) nxt = S_WAIT;
        default:        nxt = S_IDLE;
      endcase
    end
    enter_wait = (nxt == S_WAIT) && (cur != S_WAIT);
    enter_go   = (nxt == S_GO)   && (cur != S_GO);
    to_done    = (cur == S_GO)   && (nxt == S_DONE);
    to_foul    = (cur == S_WAIT) && (nxt == S_FOUL);
  end

  assign state  = cur;
  assign go_led = (cur == S_GO);

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
    end else if (enter_wait || enter_go) begin
      presc <= '0;
    end else if (cur == S_WAIT || cur == S_GO) begin
      presc <= tick ? '0 : presc + PRE_W'(1);
    end else begin
      presc <= '0;
    end
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      dly_cnt <= '0;
    end else if (enter_wait) begin
      dly_cnt <= DLY_W'(DELAY_BASE) + DLY_W'(lfsr[11:0]);
    end else if (cur == S_WAIT && tick && dly_cnt != '0) begin
      dly_cnt <= dly_cnt - DLY_W'(1);
    end
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      done    <= 1'b0;
      timeout <= 1'b0;
      foul    <= '0;
      winner  <= '0;
    end else begin
      done <= to_done;
      if (clr_p || enter_wait) begin
        timeout <= 1'b0;
        foul    <= '0;
        winner  <= '0;
      end else begin
        if (to_foul) foul <= btn_p;
        if (to_done) begin
          timeout <= sat;
          winner  <= sat ? '0 : first_idx;
        end
      end
    end
  end

  // A press in the same cycle as a tick freezes the count before that tick
  assign cnt_clr = clr_p || enter_wait || enter_go;
  assign cnt_inc = (cur == S_GO) && tick && !any_btn && !sat;

  bcd_counter #(.DIGITS(DIGITS)) u_time (
    .clk   (sysclk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .count (time_bcd),
    .sat   (sat)
  );

`ifdef REACTION_BEST_TIME_EN
  // Survives clr; only reset returns it to all 9s
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      best_bcd <= {DIGITS{4'h9}};
    end else if (to_done && !sat && (time_bcd < best_bcd)) begin
      best_bcd <= time_bcd;
    end
  end
`else
  // No best-time tracking in this build.
`endif

endmodule
